// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int UART_DATA_W          = 8;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with configurable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// 8N1 UART receiver, MSB first, with centre sampling and a valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_data,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   valid,
    input  logic                   ready,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_W);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_data),
        .q     (rx_s)
    );

    uart_state_t            state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [UART_DATA_W-1:0] shreg, shreg_n;
    logic [UART_DATA_W-1:0] dout_n;
    logic                   valid_n, frame_err_n, overrun_n;
    logic                   good;
    logic [1:0]             flush;
    logic                   armed, armed_n;

    // The synchroniser reads idle for two cycles after reset regardless of the pin;
    // only arm start detection once the real line has been seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush <= '0;
        end else begin
            flush <= {flush[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            dout      <= dout_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
            armed     <= armed_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        shreg_n     = shreg;
        dout_n      = dout;
        valid_n     = valid;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        armed_n     = armed;
        good        = 1'b0;

        if (valid && ready) begin
            valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_s && flush[1]) begin
                    armed_n = 1'b1;
                end
                if (!rx_s && armed) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    idx_n   = IDX_W'(UART_DATA_W - 1);
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n        = '0;
                    shreg_n[idx] = rx_s;
                    if (idx == '0) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx - 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        good = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        if (good) begin
            if (!valid || ready) begin
                dout_n  = shreg;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_data;
    logic [7:0] dout;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int n_load = 0, n_vcyc = 0, n_fe = 0, n_ov = 0;
    logic [7:0] last_load = 8'h00;
    logic valid_prev = 1'b0;
    int b_load, b_vcyc, b_fe, b_ov;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Event monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1 && valid_prev !== 1'b1) begin
            n_load++;
            last_load = dout;
        end
        valid_prev = valid;
        if (valid === 1'b1)     n_vcyc++;
        if (frame_err === 1'b1) n_fe++;
        if (overrun === 1'b1)   n_ov++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_load = n_load;
        b_vcyc = n_vcyc;
        b_fe   = n_fe;
        b_ov   = n_ov;
    endtask

    task automatic send_bit(input logic b);
        rx_data = b;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        send_bit(stop_bit);
        rx_data = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        rx_data = 1'b1;
        ready   = 1'b0;
        @(negedge clk);
        idle(2);
        reset = 1'b0;
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        idle(10);

        // Basic frame
        ready = 1'b1;
        snap();
        send_frame(8'hCD, 1'b1);
        idle(20);
        check("basic_loads", 32'(n_load - b_load), 32'd1);
        check("basic_valid_cycles", 32'(n_vcyc - b_vcyc), 32'd1);
        check("basic_dout", 32'(last_load), 32'hCD);
        check("basic_fe", 32'(n_fe - b_fe), 32'd0);
        check("basic_ov", 32'(n_ov - b_ov), 32'd0);
        check("basic_valid_low", 32'(valid), 32'd0);

        // Glitch rejection
        snap();
        rx_data = 1'b0;
        idle(4);
        rx_data = 1'b1;
        idle(40);
        check("glitch_loads", 32'(n_load - b_load), 32'd0);
        check("glitch_fe", 32'(n_fe - b_fe), 32'd0);
        check("glitch_valid", 32'(valid), 32'd0);
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("after_glitch_loads", 32'(n_load - b_load), 32'd1);
        check("after_glitch_dout", 32'(last_load), 32'hA5);

        // Frame error
        snap();
        send_frame(8'h3C, 1'b0);
        idle(40);
        check("ferr_pulse_cycles", 32'(n_fe - b_fe), 32'd1);
        check("ferr_loads", 32'(n_load - b_load), 32'd0);
        check("ferr_valid", 32'(valid), 32'd0);
        send_frame(8'h55, 1'b1);
        idle(20);
        check("after_ferr_loads", 32'(n_load - b_load), 32'd1);
        check("after_ferr_dout", 32'(last_load), 32'h55);
        check("after_ferr_fe", 32'(n_fe - b_fe), 32'd1);

        // Overrun
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_dout", 32'(dout), 32'h11);
        check("ovr_pulse_cycles", 32'(n_ov - b_ov), 32'd1);
        check("ovr_loads", 32'(n_load - b_load), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("ovr_accept_valid", 32'(valid), 32'd0);
        check("ovr_accept_dout", 32'(dout), 32'h11);
        idle(20);

        // Simultaneous accept: stop sample of 8'h22 lands on the 155th edge after the start bit is driven
        snap();
        send_frame(8'h11, 1'b1);
        idle(4);
        check("sim_first_valid", 32'(valid), 32'd1);
        check("sim_first_dout", 32'(dout), 32'h11);
        fork
            send_frame(8'h22, 1'b1);
            begin
                idle(154);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        idle(4);
        check("sim_valid", 32'(valid), 32'd1);
        check("sim_dout", 32'(dout), 32'h22);
        check("sim_ov", 32'(n_ov - b_ov), 32'd0);

        // Reset mid-frame: reset lands inside data bit 3 (line low) of 8'hF0
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_data = 1'b0;
        idle(4);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("midrst_dout", 32'(dout), 32'h00);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        idle(CPB - 6);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        send_bit(1'b1);
        idle(40);
        check("midrst_loads", 32'(n_load - b_load), 32'd0);
        check("midrst_fe", 32'(n_fe - b_fe), 32'd0);
        check("midrst_ov", 32'(n_ov - b_ov), 32'd0);
        ready = 1'b1;
        send_frame(8'h0F, 1'b1);
        idle(20);
        check("after_rst_loads", 32'(n_load - b_load), 32'd1);
        check("after_rst_dout", 32'(last_load), 32'h0F);
        check("after_rst_fe", 32'(n_fe - b_fe), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_rx
